regfile_wr_arbiter: RTL and testbench

- Shares the write port of a bank of NUM_REGS registers (REG_WIDTH bits each) among NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Arbitration is round-robin, with optional burst locking.
- The block drives a one-hot per-register load vector and a shared data bus, one cycle after the accept.
- It sits between the requesters and the register instances, driving each register's load_i and d_i.

---
 rtl/regfile_wr_arbiter_if.sv | 25 ++
 rtl/regfile_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write handshake bundle for regfile_wr_arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_REGS  = 16,
    parameter int REG_WIDTH = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ-1:0]           req_lock_i;
    logic [NUM_REQ*AW-1:0]        req_addr_i;
    logic [NUM_REQ*REG_WIDTH-1:0] req_data_i;

    modport master (
        output req_valid_i, req_lock_i, req_addr_i, req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i, req_lock_i, req_addr_i, req_data_i,
        output req_ready_o
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for a register bank, with burst locking and lock timeout.
// Define REGFILE_WR_ARBITER_FIXED_PRIO_EN to give requester 0 fixed priority while idle.
module regfile_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_REGS     = 16,
    parameter int REG_WIDTH    = 32,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_wr_arbiter_if.slave        req,
    output logic [NUM_REGS-1:0]        load_o,
    output logic [REG_WIDTH-1:0]       d_o,
    output logic                       err_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       locked_o
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic                 locked_q, locked_d;
    logic [NUM_REGS-1:0]  load_q, load_d;
    logic [REG_WIDTH-1:0] d_q, d_d;
    logic                 err_q, err_d;

    logic                 found;
    logic [PW-1:0]        gidx;
    logic                 accept;
    logic [AW-1:0]        sel_addr;
    logic [REG_WIDTH-1:0] sel_data;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
    endfunction

    // Grant selection: the lock owner only, or the first valid requester from the pointer.
    always_comb begin
        int idx;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        if (state_q == LOCKED) begin
            found = req.req_valid_i[owner_q];
            gidx  = owner_q;
        end else begin
`ifdef REGFILE_WR_ARBITER_FIXED_PRIO_EN
            if (req.req_valid_i[0]) begin
                found = 1'b1;
                gidx  = '0;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!found && idx != 0 && req.req_valid_i[idx]) begin
                    found = 1'b1;
                    gidx  = PW'(idx);
                end
            end
`else
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!found && req.req_valid_i[idx]) begin
                    found = 1'b1;
                    gidx  = PW'(idx);
                end
            end
`endif
        end
    end

    assign req.req_ready_o = (rst_n && found) ? (NUM_REQ'(1) << gidx) : '0;
    assign accept          = rst_n && found;
    assign sel_addr        = req.req_addr_i[int'(gidx)*AW +: AW];
    assign sel_data        = req.req_data_i[int'(gidx)*REG_WIDTH +: REG_WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        load_d  = '0;
        d_d     = d_q;
        err_d   = 1'b0;

        if (accept) begin
            owner_d = gidx;
            d_d     = sel_data;
            if (int'(sel_addr) < NUM_REGS) load_d = NUM_REGS'(1) << sel_addr;
            else                           err_d  = 1'b1;
        end

        if (state_q == IDLE) begin
            if (accept) begin
`ifdef REGFILE_WR_ARBITER_FIXED_PRIO_EN
                if (gidx != '0) ptr_d = next_idx(gidx);
`else
                ptr_d = next_idx(gidx);
`endif
                if (req.req_lock_i[gidx]) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end
            end
        end else begin
            if (accept) begin
                if (req.req_lock_i[gidx]) begin
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                end
            end else if (cnt_q + CW'(1) == CW'(LOCK_TIMEOUT)) begin
                // Owner went quiet for too long; release so others are served next cycle.
                state_d = IDLE;
                ptr_d   = next_idx(owner_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            load_q   <= '0;
            d_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            load_q   <= load_d;
            d_q      <= d_d;
            err_q    <= err_d;
        end
    end

    assign load_o   = load_q;
    assign d_o      = d_q;
    assign err_o    = err_q;
    assign owner_o  = owner_q;
    assign locked_o = locked_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (4 requesters, 12 registers so addresses 12..15 are out of range).
module tb_regfile_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int NUM_REGS = 12;
    localparam int REG_WIDTH = 32;
    localparam int LOCK_TIMEOUT = 15;
    localparam int AW = $clog2(NUM_REGS);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REGS-1:0]  load_o;
    logic [REG_WIDTH-1:0] d_o;
    logic                 err_o;
    logic [1:0]           owner_o;
    logic                 locked_o;

    int vectors = 0;
    int miscompares = 0;

    regfile_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH)) bus ();

    regfile_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(bus),
        .load_o(load_o), .d_o(d_o), .err_o(err_o), .owner_o(owner_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic lk,
                           input logic [AW-1:0] a, input logic [REG_WIDTH-1:0] dat);
        bus.req_valid_i[i]                    = v;
        bus.req_lock_i[i]                     = lk;
        bus.req_addr_i[i*AW +: AW]            = a;
        bus.req_data_i[i*REG_WIDTH +: REG_WIDTH] = dat;
    endtask

    task automatic clear_all();
        bus.req_valid_i = '0;
        bus.req_lock_i  = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_all();
        rst_n = 1'b0;
        bus.req_valid_i = '1;
        #1;
        chk("ready_in_reset", 64'(bus.req_ready_o), 64'h0);
        tick();
        tick();
        chk("rst_load", 64'(load_o), 64'h0);
        chk("rst_d", 64'(d_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_owner", 64'(owner_o), 64'h0);
        chk("rst_locked", 64'(locked_o), 64'h0);
        clear_all();
        rst_n = 1'b1;

        // Single write
        set_req(0, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        #1;
        chk("single_ready", 64'(bus.req_ready_o), 64'h1);
        tick();
        clear_all();
        chk("single_load", 64'(load_o), 64'h008);
        chk("single_d", 64'(d_o), 64'hDEADBEEF);
        tick();
        chk("single_load_clr", 64'(load_o), 64'h0);
        chk("single_d_hold", 64'(d_o), 64'hDEADBEEF);

        // Round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, AW'(i), 32'hA0 + 32'(i));
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_ready", 64'(bus.req_ready_o), 64'(1 << (c % 4)));
            tick();
            chk("rr_load", 64'(load_o), 64'(1 << (c % 4)));
            chk("rr_d", 64'(d_o), 64'h0A0 + 64'(c % 4));
            chk("rr_owner", 64'(owner_o), 64'(c % 4));
        end
        clear_all();
        tick();
        chk("rr_idle_load", 64'(load_o), 64'h0);

        // Burst lock: req1 beats lock=1, (gap), lock=1, lock=0 while req2 waits
        set_req(1, 1'b1, 1'b1, 4'd5, 32'h11);
        set_req(2, 1'b1, 1'b0, 4'd6, 32'h22);
        #1;
        chk("lk_ready_b1", 64'(bus.req_ready_o), 64'h2);
        tick();
        chk("lk_load_b1", 64'(load_o), 64'h020);
        chk("lk_locked_1", 64'(locked_o), 64'h1);
        chk("lk_owner", 64'(owner_o), 64'h1);
        set_req(1, 1'b0, 1'b1, 4'd5, 32'h12);
        #1;
        chk("lk_ready_gap", 64'(bus.req_ready_o), 64'h0);
        tick();
        chk("lk_load_gap", 64'(load_o), 64'h0);
        chk("lk_locked_2", 64'(locked_o), 64'h1);
        set_req(1, 1'b1, 1'b1, 4'd5, 32'h12);
        #1;
        chk("lk_ready_b2", 64'(bus.req_ready_o), 64'h2);
        tick();
        chk("lk_d_b2", 64'(d_o), 64'h12);
        chk("lk_locked_3", 64'(locked_o), 64'h1);
        set_req(1, 1'b1, 1'b0, 4'd5, 32'h13);
        #1;
        chk("lk_ready_b3", 64'(bus.req_ready_o), 64'h2);
        tick();
        chk("lk_d_b3", 64'(d_o), 64'h13);
        chk("lk_locked_off", 64'(locked_o), 64'h0);
        set_req(1, 1'b0, 1'b0, 4'd0, 32'h0);
        #1;
        chk("lk_ready_req2", 64'(bus.req_ready_o), 64'h4);
        tick();
        chk("lk_load_req2", 64'(load_o), 64'h040);
        chk("lk_d_req2", 64'(d_o), 64'h22);
        clear_all();

        // Lock timeout: req2 locks then goes quiet, req0 waits
        set_req(2, 1'b1, 1'b1, 4'd7, 32'h77);
        #1;
        chk("to_ready_lock", 64'(bus.req_ready_o), 64'h4);
        tick();
        chk("to_locked", 64'(locked_o), 64'h1);
        clear_all();
        set_req(0, 1'b1, 1'b0, 4'd0, 32'h33);
        for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
            #1;
            chk("to_ready_blocked", 64'(bus.req_ready_o), 64'h0);
            tick();
            chk("to_locked_k", 64'(locked_o), (k < LOCK_TIMEOUT) ? 64'h1 : 64'h0);
        end
        #1;
        chk("to_ready_req0", 64'(bus.req_ready_o), 64'h1);
        tick();
        chk("to_load_req0", 64'(load_o), 64'h001);
        chk("to_d_req0", 64'(d_o), 64'h33);
        clear_all();

        // Out of range (addr 13 >= 12) and top in-range address 11
        set_req(3, 1'b1, 1'b0, 4'd13, 32'h44);
        #1;
        chk("oor_ready", 64'(bus.req_ready_o), 64'h8);
        tick();
        chk("oor_load", 64'(load_o), 64'h0);
        chk("oor_err", 64'(err_o), 64'h1);
        set_req(3, 1'b1, 1'b0, 4'd11, 32'h45);
        #1;
        chk("edge_ready", 64'(bus.req_ready_o), 64'h8);
        tick();
        chk("edge_load", 64'(load_o), 64'h800);
        chk("edge_err", 64'(err_o), 64'h0);
        clear_all();
        tick();
        chk("oor_err_clr", 64'(err_o), 64'h0);

        // Reset while locked with req1 still pushing beats
        set_req(1, 1'b1, 1'b1, 4'd2, 32'h55);
        #1;
        chk("rl_ready", 64'(bus.req_ready_o), 64'h2);
        tick();
        chk("rl_load", 64'(load_o), 64'h004);
        chk("rl_locked", 64'(locked_o), 64'h1);
        set_req(1, 1'b1, 1'b1, 4'd2, 32'h56);
        rst_n = 1'b0;
        #1;
        chk("rl_ready_rst", 64'(bus.req_ready_o), 64'h0);
        tick();
        rst_n = 1'b1;
        chk("rl_load_after", 64'(load_o), 64'h0);
        chk("rl_locked_after", 64'(locked_o), 64'h0);
        chk("rl_d_after", 64'(d_o), 64'h0);
        set_req(0, 1'b1, 1'b0, 4'd1, 32'h66);
        set_req(3, 1'b1, 1'b0, 4'd4, 32'h67);
        #1;
        chk("rl_ptr_zero", 64'(bus.req_ready_o), 64'h1);
        tick();
        chk("rl_load_req0", 64'(load_o), 64'h002);
        clear_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
